// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared constants, source indices and FSM states for the UART TX packetizer
package uart_pkt_pkg;

    localparam int PKT_W   = 40;
    localparam int NUM_SRC = 4;

    localparam logic [7:0] UART_HDR_ADS_DATA = 8'hAA;
    localparam logic [7:0] UART_HDR_MPR_DATA = 8'hBB;
    localparam logic [7:0] UART_HDR_ADS_REG  = 8'h61;
    localparam logic [7:0] UART_HDR_MPR_REG  = 8'h6D;

    // Lower index wins arbitration
    typedef enum logic [1:0] {
        SRC_ADS_REG  = 2'd0,
        SRC_MPR_REG  = 2'd1,
        SRC_ADS_DATA = 2'd2,
        SRC_MPR_DATA = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_WAIT_RDY = 2'd2
    } tx_state_e;

    function automatic logic [NUM_SRC-1:0] prio_grant(input logic [NUM_SRC-1:0] req);
        logic [NUM_SRC-1:0] g;
        g = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// rtl/uart_pkt_fifo.sv - single-clock first-word-fall-through packet FIFO with registered empty flag
module uart_pkt_fifo #(
    parameter int WIDTH      = 40,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_PUSH,
    input  logic [WIDTH-1:0] i_DATA,
    input  logic             i_POP,
    input  logic             i_FLUSH,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_FULL,
    output logic             o_EMPTY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic                empty_q;
    logic                do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign o_FULL  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign o_EMPTY = empty_q;
    assign o_DATA  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign do_pop  = i_POP && !empty_q;
    assign do_push = i_PUSH && (!o_FULL || do_pop);

    always_comb begin
        wr_nxt = wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_nxt = rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_q <= 1'b1;
        end else if (i_FLUSH) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            empty_q <= 1'b1;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            empty_q <= (wr_nxt == rd_nxt);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (do_push && !i_FLUSH) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= i_DATA;
        end
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// rtl/uart_tx_packetizer.sv - frames four sources into 40-bit packets and feeds the UART TX; UART_TX_OVF_CNT_EN enables the drop counter
module uart_tx_packetizer
    import uart_pkt_pkg::*;
#(
    parameter int         FIFO_DEPTH_LOG2 = 3,
    parameter logic [7:0] HDR_ADS_DATA    = UART_HDR_ADS_DATA,
    parameter logic [7:0] HDR_MPR_DATA    = UART_HDR_MPR_DATA,
    parameter logic [7:0] HDR_ADS_REG     = UART_HDR_ADS_REG,
    parameter logic [7:0] HDR_MPR_REG     = UART_HDR_MPR_REG
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [31:0]      i_ADS_DATA,
    input  logic             i_ADS_DATA_VALID,
    input  logic [15:0]      i_MPR_DATA,
    input  logic             i_MPR_DATA_VALID,
    input  logic [15:0]      i_ADS_REG_DATA,
    input  logic             i_ADS_REG_VALID,
    input  logic [15:0]      i_MPR_REG_DATA,
    input  logic             i_MPR_REG_VALID,
    input  logic             i_FLUSH,
    output logic [PKT_W-1:0] o_UART_DATA_TX,
    output logic             o_UART_DATA_TX_VALID,
    input  logic             i_UART_DATA_TX_READY,
    output logic [7:0]       o_OVF_CNT,
    output logic             o_FIFO_EMPTY
);

    logic [PKT_W-1:0]   frame    [NUM_SRC];
    logic [PKT_W-1:0]   in_pkt   [NUM_SRC];
    logic [PKT_W-1:0]   slot_pkt [NUM_SRC];
    logic [NUM_SRC-1:0] strobe, in_vld, slot_vld, grant;
    logic [PKT_W-1:0]   push_pkt, fifo_head;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               ready_q, ready_fall, load_tx, clr_valid;
    tx_state_e          state_q, state_d;

    always_comb begin
        frame[SRC_ADS_REG]   = {HDR_ADS_REG, i_ADS_REG_DATA, 16'h0000};
        frame[SRC_MPR_REG]   = {HDR_MPR_REG, i_MPR_REG_DATA, 16'h0000};
        frame[SRC_ADS_DATA]  = {HDR_ADS_DATA, i_ADS_DATA};
        frame[SRC_MPR_DATA]  = {HDR_MPR_DATA, i_MPR_DATA, 16'h0000};
        strobe               = '0;
        strobe[SRC_ADS_REG]  = i_ADS_REG_VALID;
        strobe[SRC_MPR_REG]  = i_MPR_REG_VALID;
        strobe[SRC_ADS_DATA] = i_ADS_DATA_VALID;
        strobe[SRC_MPR_DATA] = i_MPR_DATA_VALID;
    end

    assign grant = fifo_full ? '0 : prio_grant(slot_vld);

    always_comb begin
        push_pkt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) push_pkt = slot_pkt[i];
        end
    end

    // Inputs are registered once, then land in a per-source slot; a draining slot may reload
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            in_vld   <= '0;
            slot_vld <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                in_pkt[i]   <= '0;
                slot_pkt[i] <= '0;
            end
        end else begin
            in_vld <= i_FLUSH ? '0 : strobe;
            for (int i = 0; i < NUM_SRC; i++) begin
                in_pkt[i] <= frame[i];
                if (i_FLUSH) begin
                    slot_vld[i] <= 1'b0;
                end else if (in_vld[i] && (!slot_vld[i] || grant[i])) begin
                    slot_vld[i] <= 1'b1;
                    slot_pkt[i] <= in_pkt[i];
                end else if (grant[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    uart_pkt_fifo #(
        .WIDTH      (PKT_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_PUSH  (|grant),
        .i_DATA  (push_pkt),
        .i_POP   (fifo_pop),
        .i_FLUSH (i_FLUSH),
        .o_DATA  (fifo_head),
        .o_FULL  (fifo_full),
        .o_EMPTY (fifo_empty)
    );

    assign o_FIFO_EMPTY = fifo_empty;
    // Only a READY falling edge proves the controller captured the packet
    assign ready_fall   = ready_q && !i_UART_DATA_TX_READY;

    always_comb begin
        state_d   = state_q;
        load_tx   = 1'b0;
        clr_valid = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!i_FLUSH) begin
                    if (!fifo_empty) begin
                        load_tx = 1'b1;
                        state_d = ST_OFFER;
                    end else if (ready_fall) begin
                        state_d = ST_WAIT_RDY;
                    end
                end
            end
            ST_OFFER: begin
                if (i_FLUSH) begin
                    clr_valid = 1'b1;
                    state_d   = ST_WAIT_RDY;
                end else if (ready_fall) begin
                    fifo_pop  = 1'b1;
                    clr_valid = 1'b1;
                    state_d   = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (!i_FLUSH && i_UART_DATA_TX_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q              <= ST_IDLE;
            ready_q              <= 1'b0;
            o_UART_DATA_TX       <= '0;
            o_UART_DATA_TX_VALID <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= i_UART_DATA_TX_READY;
            if (load_tx) begin
                o_UART_DATA_TX       <= fifo_head;
                o_UART_DATA_TX_VALID <= 1'b1;
            end else if (clr_valid) begin
                o_UART_DATA_TX_VALID <= 1'b0;
            end
        end
    end

`ifdef UART_TX_OVF_CNT_EN
    logic [NUM_SRC-1:0] drop;
    logic [2:0]         drop_cnt;
    logic [8:0]         ovf_sum;
    logic [7:0]         ovf_q;

    always_comb begin
        drop     = i_FLUSH ? '0 : (in_vld & slot_vld & ~grant);
        drop_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_cnt = drop_cnt + {2'b00, drop[i]};
        end
        ovf_sum = {1'b0, ovf_q} + {6'b000000, drop_cnt};
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        end
    end

    assign o_OVF_CNT = ovf_q;
`else
    assign o_OVF_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb/tb_uart_tx_packetizer.sv - directed self-checking bench for uart_tx_packetizer
module tb_uart_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ads_data = '0;
    logic        ads_vld = 1'b0;
    logic [15:0] mpr_data = '0;
    logic        mpr_vld = 1'b0;
    logic [15:0] ads_reg = '0;
    logic        ads_reg_vld = 1'b0;
    logic [15:0] mpr_reg = '0;
    logic        mpr_reg_vld = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b1;
    logic [39:0] tx_data;
    logic        tx_valid;
    logic [7:0]  ovf_cnt;
    logic        fifo_empty;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_OVF_CNT_EN
    localparam logic [7:0] EXP_OVF = 8'd1;
`else
    localparam logic [7:0] EXP_OVF = 8'd0;
`endif

    always #5 clk = ~clk;

    uart_tx_packetizer dut (
        .i_CLK                (clk),
        .i_RST                (rst),
        .i_ADS_DATA           (ads_data),
        .i_ADS_DATA_VALID     (ads_vld),
        .i_MPR_DATA           (mpr_data),
        .i_MPR_DATA_VALID     (mpr_vld),
        .i_ADS_REG_DATA       (ads_reg),
        .i_ADS_REG_VALID      (ads_reg_vld),
        .i_MPR_REG_DATA       (mpr_reg),
        .i_MPR_REG_VALID      (mpr_reg_vld),
        .i_FLUSH              (flush),
        .o_UART_DATA_TX       (tx_data),
        .o_UART_DATA_TX_VALID (tx_valid),
        .i_UART_DATA_TX_READY (ready),
        .o_OVF_CNT            (ovf_cnt),
        .o_FIFO_EMPTY         (fifo_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Controller capture: READY drops for one cycle, recovers, then the FSM may reoffer
    task automatic handshake();
        ready = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data", {24'h0, tx_data}, 64'h0);
        chk("rst_valid", {63'h0, tx_valid}, 64'h0);
        chk("rst_ovf", {56'h0, ovf_cnt}, 64'h0);
        chk("rst_empty", {63'h0, fifo_empty}, 64'h1);
        rst = 1'b0;
        tick();
        tick();

        // Single ADS sample, latency to VALID
        ads_data = 32'h11223344;
        ads_vld  = 1'b1;
        tick();
        ads_vld = 1'b0;
        tick();
        chk("t1_valid_e1", {63'h0, tx_valid}, 64'h0);
        tick();
        chk("t1_valid_e2", {63'h0, tx_valid}, 64'h0);
        chk("t1_empty_e2", {63'h0, fifo_empty}, 64'h0);
        tick();
        chk("t1_valid_e3", {63'h0, tx_valid}, 64'h1);
        chk("t1_data", {24'h0, tx_data}, {24'h0, 40'hAA11223344});
        ready = 1'b0;
        tick();
        chk("t1_valid_acc", {63'h0, tx_valid}, 64'h0);
        chk("t1_empty_acc", {63'h0, fifo_empty}, 64'h1);
        ready = 1'b1;
        tick();

        // Simultaneous MPR sample and ADS register readback
        mpr_data    = 16'hBEEF;
        mpr_vld     = 1'b1;
        ads_reg     = 16'h0142;
        ads_reg_vld = 1'b1;
        tick();
        mpr_vld     = 1'b0;
        ads_reg_vld = 1'b0;
        tick();
        tick();
        tick();
        chk("t2_valid1", {63'h0, tx_valid}, 64'h1);
        chk("t2_data1", {24'h0, tx_data}, {24'h0, 40'h6101420000});
        handshake();
        chk("t2_valid2", {63'h0, tx_valid}, 64'h1);
        chk("t2_data2", {24'h0, tx_data}, {24'h0, 40'hBBBEEF0000});
        handshake();
        chk("t2_valid_end", {63'h0, tx_valid}, 64'h0);
        chk("t2_empty_end", {63'h0, fifo_empty}, 64'h1);

        // Ten ADS samples with the controller stalled: 8 queued, 1 in the slot, 1 dropped
        ready = 1'b0;
        tick();
        for (int k = 1; k <= 10; k++) begin
            ads_data = 32'h10000000 + k;
            ads_vld  = 1'b1;
            tick();
            ads_vld = 1'b0;
            tick();
        end
        tick();
        tick();
        chk("t3_valid_stall", {63'h0, tx_valid}, 64'h0);
        chk("t3_empty_stall", {63'h0, fifo_empty}, 64'h0);
        chk("t3_ovf", {56'h0, ovf_cnt}, {56'h0, EXP_OVF});
        ready = 1'b1;
        tick();
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("t3_valid_%0d", k), {63'h0, tx_valid}, 64'h1);
            chk($sformatf("t3_data_%0d", k), {24'h0, tx_data}, {24'h0, 8'hAA, 32'h10000000 + k});
            handshake();
        end
        chk("t3_valid_end", {63'h0, tx_valid}, 64'h0);
        chk("t3_empty_end", {63'h0, fifo_empty}, 64'h1);

        // Offer held while READY stays high (controller busy)
        ads_data = 32'hCAFEF00D;
        ads_vld  = 1'b1;
        tick();
        ads_vld = 1'b0;
        tick();
        tick();
        tick();
        for (int c = 0; c < 50; c++) begin
            chk("t4_hold_data", {24'h0, tx_data}, {24'h0, 40'hAACAFEF00D});
            chk("t4_hold_valid", {63'h0, tx_valid}, 64'h1);
            tick();
        end
        chk("t4_empty_hold", {63'h0, fifo_empty}, 64'h0);
        ready = 1'b0;
        tick();
        chk("t4_valid_acc", {63'h0, tx_valid}, 64'h0);
        chk("t4_empty_acc", {63'h0, fifo_empty}, 64'h1);
        ready = 1'b1;
        tick();

        // Flush while offering with four packets queued
        ads_reg     = 16'hA1B2;
        ads_reg_vld = 1'b1;
        mpr_reg     = 16'h0304;
        mpr_reg_vld = 1'b1;
        ads_data    = 32'h01020304;
        ads_vld     = 1'b1;
        mpr_data    = 16'h0506;
        mpr_vld     = 1'b1;
        tick();
        ads_reg_vld = 1'b0;
        mpr_reg_vld = 1'b0;
        ads_vld     = 1'b0;
        mpr_vld     = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_first", {24'h0, tx_data}, {24'h0, 40'h61A1B20000});
        tick();
        tick();
        chk("t5_valid_pre", {63'h0, tx_valid}, 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_valid_flush", {63'h0, tx_valid}, 64'h0);
        chk("t5_empty_flush", {63'h0, fifo_empty}, 64'h1);
        chk("t5_ovf_kept", {56'h0, ovf_cnt}, {56'h0, EXP_OVF});
        ready    = 1'b0;
        ads_data = 32'h55667788;
        ads_vld  = 1'b1;
        tick();
        ads_vld = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("t5_wait_valid", {63'h0, tx_valid}, 64'h0);
        chk("t5_wait_empty", {63'h0, fifo_empty}, 64'h0);
        ready = 1'b1;
        tick();
        tick();
        chk("t5_reoffer_valid", {63'h0, tx_valid}, 64'h1);
        chk("t5_reoffer_data", {24'h0, tx_data}, {24'h0, 40'hAA55667788});

        // Asynchronous reset while offering
        #2;
        rst = 1'b1;
        #1;
        chk("t6_data", {24'h0, tx_data}, 64'h0);
        chk("t6_valid", {63'h0, tx_valid}, 64'h0);
        chk("t6_ovf", {56'h0, ovf_cnt}, 64'h0);
        chk("t6_empty", {63'h0, fifo_empty}, 64'h1);
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
